ahb_user_arbiter: RTL and testbench

- Shares the single `ahb_lite` master user interface among `NREQ` requesters.
- Arbitrates round-robin and holds the grant for a whole burst; the beat count follows the burst type.
- Drives the `HAUSER`/`HWUSER`/`HSUSER`/`HBUSER`/`HWSUSER`/`input_HB_valid`/`input_data_valid` user side, and routes the read return back to the burst owner.
- Sits between the client blocks and `ahb_lite`, in the same clock domain.

---
 rtl/ahb_user_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_ahb_user_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_user_arbiter.sv
// Round-robin arbiter that shares the ahb_lite user-side master port among NREQ clients, one whole burst at a time.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ahb_user_arbiter #(
  parameter int NREQ       = 4,
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input  logic                       clk,
  input  logic                       HRESETn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*addr_width-1:0] req_addr,
  input  logic [3*NREQ-1:0]          req_burst,
  input  logic [3*NREQ-1:0]          req_size,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*data_width-1:0] req_wdata,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_grant,
  output logic [NREQ-1:0]            beat_ack,
  output logic [data_width-1:0]      rd_data,
  output logic [NREQ-1:0]            rd_valid,
  input  logic                       HREAdy,
  input  logic [data_width-1:0]      HRUSER,
  input  logic                       read_valid,
  output logic [addr_width-1:0]      HAUSER,
  output logic [data_width-1:0]      HWUSER,
  output logic [2:0]                 HSUSER,
  output logic [2:0]                 HBUSER,
  output logic                       HWSUSER,
  output logic                       input_HB_valid,
  output logic                       input_data_valid
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] B_INCR = 3'd1;

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [PW-1:0]         owner_reg, owner_next;
  logic [NREQ-1:0]       grant_reg, grant_next;
  logic [4:0]            beats_left_reg, beats_left_next;
  logic                  drain_cnt_reg, drain_cnt_next;
  logic [addr_width-1:0] haddr_reg, haddr_next;
  logic [2:0]            hsize_reg, hsize_next;
  logic [2:0]            hburst_reg, hburst_next;
  logic                  hwrite_reg, hwrite_next;
  logic [PW-1:0]         rr_ptr;
  logic                  tag0_rd_reg, tag1_rd_reg;
  logic [PW-1:0]         tag0_own_reg, tag1_own_reg;
  logic [PW-1:0]         winner;
  logic                  winner_found;

  logic [addr_width-1:0] addr_arr  [NREQ];
  logic [data_width-1:0] wdata_arr [NREQ];
  logic [2:0]            burst_arr [NREQ];
  logic [2:0]            size_arr  [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*addr_width +: addr_width];
      assign wdata_arr[gi] = req_wdata[gi*data_width +: data_width];
      assign burst_arr[gi] = req_burst[gi*3 +: 3];
      assign size_arr[gi]  = req_size[gi*3 +: 3];
    end
  endgenerate

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PW-1:0] rr_ptr_reg;
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn)
      rr_ptr_reg <= '0;
    else if (state_reg == DRAIN && drain_cnt_reg)
      rr_ptr_reg <= (int'(owner_reg) == NREQ-1) ? '0 : owner_reg + 1'b1;
  end
  assign rr_ptr = rr_ptr_reg;
`endif

  // First pending requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    int idx;
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!winner_found && req_valid[PW'(idx)]) begin
        winner       = PW'(idx);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    grant_next       = grant_reg;
    beats_left_next  = beats_left_reg;
    drain_cnt_next   = drain_cnt_reg;
    haddr_next       = haddr_reg;
    hsize_next       = hsize_reg;
    hburst_next      = hburst_reg;
    hwrite_next      = hwrite_reg;
    beat_ack         = '0;
    HWUSER           = '0;
    input_HB_valid   = 1'b0;
    input_data_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (winner_found) begin
          state_next  = GRANT;
          owner_next  = winner;
          grant_next  = NREQ'(1) << winner;
          haddr_next  = addr_arr[winner];
          hsize_next  = size_arr[winner];
          hburst_next = burst_arr[winner];
          hwrite_next = req_write[winner];
        end
      end
      GRANT: begin
        input_HB_valid = 1'b1;
        case (hburst_reg)
          3'd0:       beats_left_next = 5'd1;
          3'd1:       beats_left_next = 5'd0;
          3'd2, 3'd3: beats_left_next = 5'd4;
          3'd4, 3'd5: beats_left_next = 5'd8;
          default:    beats_left_next = 5'd16;
        endcase
        state_next = BURST;
      end
      BURST: begin
        HWUSER = wdata_arr[owner_reg];
        if (HREAdy) begin
          beat_ack = grant_reg;
          if (hburst_reg == B_INCR) begin
            if (req_last[owner_reg]) begin
              input_data_valid = 1'b1;
              drain_cnt_next   = 1'b0;
              state_next       = DRAIN;
            end
          end else begin
            // Guarded decrement: the counter saturates at zero.
            if (beats_left_reg != 5'd0) beats_left_next = beats_left_reg - 5'd1;
            if (beats_left_reg <= 5'd1) begin
              drain_cnt_next = 1'b0;
              state_next     = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_reg) begin
          state_next     = IDLE;
          drain_cnt_next = 1'b0;
          grant_next     = '0;
          haddr_next     = '0;
          hsize_next     = '0;
          hburst_next    = '0;
          hwrite_next    = 1'b0;
        end else begin
          drain_cnt_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      grant_reg      <= '0;
      beats_left_reg <= '0;
      drain_cnt_reg  <= 1'b0;
      haddr_reg      <= '0;
      hsize_reg      <= '0;
      hburst_reg     <= '0;
      hwrite_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      grant_reg      <= grant_next;
      beats_left_reg <= beats_left_next;
      drain_cnt_reg  <= drain_cnt_next;
      haddr_reg      <= haddr_next;
      hsize_reg      <= hsize_next;
      hburst_reg     <= hburst_next;
      hwrite_reg     <= hwrite_next;
    end
  end

  // Owner tag follows each accepted beat through the two-stage read data pipeline.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      tag0_rd_reg  <= 1'b0;
      tag0_own_reg <= '0;
      tag1_rd_reg  <= 1'b0;
      tag1_own_reg <= '0;
    end else if (HREAdy) begin
      tag0_rd_reg  <= (state_reg == BURST) && !hwrite_reg;
      tag0_own_reg <= owner_reg;
      tag1_rd_reg  <= tag0_rd_reg;
      tag1_own_reg <= tag0_own_reg;
    end
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (read_valid && tag1_rd_reg) begin
      rd_valid = NREQ'(1) << tag1_own_reg;
      rd_data  = HRUSER;
    end
  end

  assign req_grant = grant_reg;
  assign HAUSER    = haddr_reg;
  assign HSUSER    = hsize_reg;
  assign HBUSER    = hburst_reg;
  assign HWSUSER   = hwrite_reg;

endmodule

// File: tb/tb_ahb_user_arbiter.sv
// Self-checking bench for ahb_user_arbiter: behavioural requesters plus queued expectations per scenario.
module tb_ahb_user_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 HRESETn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [3*NREQ-1:0]    req_burst;
  logic [3*NREQ-1:0]    req_size;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_grant;
  logic [NREQ-1:0]      beat_ack;
  logic [DW-1:0]        rd_data;
  logic [NREQ-1:0]      rd_valid;
  logic                 HREAdy;
  logic [DW-1:0]        HRUSER;
  logic                 read_valid;
  logic [AW-1:0]        HAUSER;
  logic [DW-1:0]        HWUSER;
  logic [2:0]           HSUSER;
  logic [2:0]           HBUSER;
  logic                 HWSUSER;
  logic                 input_HB_valid;
  logic                 input_data_valid;

  ahb_user_arbiter #(.NREQ(NREQ), .addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_burst(req_burst), .req_size(req_size),
    .req_write(req_write), .req_wdata(req_wdata), .req_last(req_last),
    .req_grant(req_grant), .beat_ack(beat_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .HREAdy(HREAdy), .HRUSER(HRUSER), .read_valid(read_valid),
    .HAUSER(HAUSER), .HWUSER(HWUSER), .HSUSER(HSUSER), .HBUSER(HBUSER), .HWSUSER(HWSUSER),
    .input_HB_valid(input_HB_valid), .input_data_valid(input_data_valid)
  );

  always #5 clk = ~clk;

  int checks, failures, cyc;
  bit   [NREQ-1:0] valid_v;
  int              bursts_left [NREQ];
  int              incr_len    [NREQ];
  int              beats_done  [NREQ];
  logic [31:0]     wbase       [NREQ];
  logic            hready_drv;
  logic [31:0]     hruser_drv;

  logic [NREQ-1:0] ob_grant, ob_ack, ob_rdv;
  logic            ob_hb, ob_idv, ob_hw;
  logic [31:0]     ob_haddr, ob_hwuser, ob_rdd;
  logic [2:0]      ob_hburst, ob_hsize;

  logic [NREQ-1:0] expg_q [$];
  logic [31:0]     expw_q [$];
  int              expc_q [$];

  function automatic int burst_beats(input logic [2:0] b, input int ilen);
    case (b)
      3'd0:       return 1;
      3'd1:       return ilen;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] b, input logic [31:0] a,
                         input logic w, input int nb, input int ilen);
    req_burst[i*3 +: 3] = b;
    req_size[i*3 +: 3]  = 3'd2;
    req_addr[i*AW +: AW] = a;
    req_write[i]        = w;
    incr_len[i]         = ilen;
    bursts_left[i]      = nb;
    beats_done[i]       = 0;
    wbase[i]            = a ^ 32'hA5A5_0000;
    valid_v[i]          = 1'b1;
  endtask

  task automatic clear_model();
    valid_v    = '0;
    hready_drv = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bursts_left[i] = 0;
      incr_len[i]    = 0;
      beats_done[i]  = 0;
      wbase[i]       = '0;
    end
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    clear_model();
    req_valid = '0;
    repeat (2) @(negedge clk);
    HRESETn = 1'b1;
  endtask

  // One clock: drive requester model and slave side, then sample outputs 1 ns later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    HREAdy     = hready_drv;
    hruser_drv = $urandom;
    HRUSER     = hruser_drv;
    read_valid = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_last[i]          = (incr_len[i] == beats_done[i] + 1);
      req_wdata[i*DW +: DW] = wbase[i] + 32'(beats_done[i]);
    end
    req_valid = valid_v;
    #1;
    ob_grant  = req_grant;  ob_ack = beat_ack;   ob_rdv = rd_valid;  ob_rdd = rd_data;
    ob_hb     = input_HB_valid;  ob_idv = input_data_valid;  ob_hw = HWSUSER;
    ob_haddr  = HAUSER;     ob_hwuser = HWUSER;  ob_hburst = HBUSER; ob_hsize = HSUSER;
    for (int i = 0; i < NREQ; i++) begin
      if (beat_ack[i]) begin
        beats_done[i]++;
        if (beats_done[i] == burst_beats(req_burst[i*3 +: 3], incr_len[i])) begin
          beats_done[i] = 0;
          bursts_left[i]--;
          if (bursts_left[i] <= 0) valid_v[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n, acks;
    HRESETn = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_grant !== '0 || beat_ack !== '0 || rd_valid !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_handshake: grant=%b ack=%b rd_valid=%b rd_data=%h, required all zero",
               req_grant, beat_ack, rd_valid, rd_data);
    end
    checks++;
    if ({HAUSER, HWUSER, HSUSER, HBUSER, HWSUSER, input_HB_valid, input_data_valid} !== '0) begin
      failures++;
      $display("FAIL reset_user: HAUSER=%h HWUSER=%h HSUSER=%0d HBUSER=%0d HWSUSER=%b hb=%b dv=%b, required all zero",
               HAUSER, HWUSER, HSUSER, HBUSER, HWSUSER, input_HB_valid, input_data_valid);
    end
    HRESETn = 1'b1;
    set_req(0, 3'd3, 32'h40, 1'b1, 100, 0);
    set_req(1, 3'd3, 32'h80, 1'b1, 100, 0);
    expg_q.push_back(4'b0001);
    acks = 0; n = 0;
    while (acks < 3 && n < 40) begin
      cycle(); n++;
      if (ob_hb) begin
        checks++;
        if (ob_grant !== expg_q[0]) begin
          failures++;
          $display("FAIL reset_first_grant: got %b, required %b", ob_grant, expg_q[0]);
        end
      end
      if (ob_ack[0]) acks++;
    end
    void'(expg_q.pop_front());
    checks++;
    if (acks != 3) begin
      failures++;
      $display("FAIL reset_midburst_timeout: saw %0d acks, required 3", acks);
    end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (req_grant !== '0 || beat_ack !== '0 || input_HB_valid !== 1'b0 || HAUSER !== '0) begin
      failures++;
      $display("FAIL reset_abort: grant=%b ack=%b hb=%b HAUSER=%h, required all zero",
               req_grant, beat_ack, input_HB_valid, HAUSER);
    end
    for (int i = 0; i < NREQ; i++) beats_done[i] = 0;
    @(negedge clk);
    HRESETn = 1'b1;
    expg_q.push_back(4'b0001);
    n = 0;
    do begin cycle(); n++; end while (!ob_hb && n < 20);
    checks++;
    if (!ob_hb || ob_grant !== expg_q[0]) begin
      failures++;
      $display("FAIL reset_regrant: hb=%b grant=%b, required hb=1 grant=%b", ob_hb, ob_grant, expg_q[0]);
    end
    void'(expg_q.pop_front());
    do_reset();
  endtask

  task automatic test_round_robin();
    int n, hbs, start, last_ack, first_hb;
    bit first_ack_done;
    logic [NREQ-1:0] eg;
    set_req(0, 3'd0, 32'h10, 1'b0, 1000, 0);
    set_req(2, 3'd0, 32'h20, 1'b0, 1000, 0);
`ifdef AHB_ARB_FIXED_PRIO_EN
    repeat (4) expg_q.push_back(4'b0001);
`else
    repeat (2) begin expg_q.push_back(4'b0001); expg_q.push_back(4'b0100); end
`endif
    start = cyc; hbs = 0; n = 0; last_ack = -100; first_hb = -100; first_ack_done = 0;
    while (hbs < 4 && n < 100) begin
      cycle(); n++;
      if (ob_hb) begin
        eg = expg_q.pop_front();
        checks++;
        if (ob_grant !== eg) begin
          failures++;
          $display("FAIL rr_grant%0d: got %b, required %b", hbs, ob_grant, eg);
        end
        checks++;
        if (hbs == 0) begin
          first_hb = cyc;
          if (cyc != start + 2) begin
            failures++;
            $display("FAIL rr_grant_latency: HB at cycle %0d, required %0d", cyc - start, 2);
          end
        end else if (cyc - last_ack != 4) begin
          failures++;
          $display("FAIL rr_gap: HB %0d cycles after last ack, required 4", cyc - last_ack);
        end
        hbs++;
      end
      if (ob_ack != '0) begin
        if (!first_ack_done) begin
          first_ack_done = 1;
          checks++;
          if (cyc != first_hb + 1) begin
            failures++;
            $display("FAIL rr_first_ack: ack %0d cycles after HB, required 1", cyc - first_hb);
          end
        end
        last_ack = cyc;
      end
    end
    checks++;
    if (hbs != 4) begin
      failures++;
      $display("FAIL rr_timeout: saw %0d grants, required 4", hbs);
    end
    expg_q.delete();
    do_reset();
  endtask

  task automatic test_incr4_write();
    int n, acks;
    logic pat [5];
    logic [31:0] ew;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    set_req(1, 3'd3, 32'h100, 1'b1, 1, 0);
    n = 0;
    do begin cycle(); n++; end while (!ob_hb && n < 10);
    checks++;
    if (!ob_hb || ob_haddr !== 32'h100 || ob_hburst !== 3'd3 || ob_hsize !== 3'd2 || ob_hw !== 1'b1
        || ob_grant !== 4'b0010) begin
      failures++;
      $display("FAIL incr4_start: hb=%b HAUSER=%h HBUSER=%0d HSUSER=%0d HWSUSER=%b grant=%b, required 1 100 3 2 1 0010",
               ob_hb, ob_haddr, ob_hburst, ob_hsize, ob_hw, ob_grant);
    end
    for (int k = 0; k < 4; k++) expw_q.push_back((32'h100 ^ 32'hA5A5_0000) + 32'(k));
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      hready_drv = pat[k];
      cycle();
      checks++;
      if (ob_ack !== (pat[k] ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL incr4_ack%0d: got %b, required %b", k, ob_ack, pat[k] ? 4'b0010 : 4'b0000);
      end
      if (ob_ack[1] && expw_q.size() > 0) begin
        ew = expw_q.pop_front();
        acks++;
        checks++;
        if (ob_hwuser !== ew) begin
          failures++;
          $display("FAIL incr4_wdata%0d: HWUSER=%h, required %h", acks, ob_hwuser, ew);
        end
      end
    end
    hready_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (ob_ack !== '0 || ob_grant !== (k < 2 ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL incr4_drain%0d: ack=%b grant=%b, required ack=0000 grant=%b",
                 k, ob_ack, ob_grant, k < 2 ? 4'b0010 : 4'b0000);
      end
    end
    checks++;
    if (acks != 4 || expw_q.size() != 0) begin
      failures++;
      $display("FAIL incr4_count: %0d acks, required 4", acks);
    end
    expw_q.delete();
    do_reset();
  endtask

  task automatic test_incr_last();
    int n, acks, idv_count, idv_at;
    set_req(3, 3'd1, 32'h300, 1'b1, 1, 6);
    n = 0;
    do begin cycle(); n++; end while (!ob_hb && n < 10);
    checks++;
    if (!ob_hb || ob_hburst !== 3'd1 || ob_grant !== 4'b1000) begin
      failures++;
      $display("FAIL incr_start: hb=%b HBUSER=%0d grant=%b, required 1 1 1000", ob_hb, ob_hburst, ob_grant);
    end
    acks = 0; idv_count = 0; idv_at = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (ob_ack[3]) acks++;
      if (ob_idv) begin idv_count++; idv_at = acks; end
    end
    checks++;
    if (acks != 6) begin
      failures++;
      $display("FAIL incr_acks: %0d acks, required 6", acks);
    end
    checks++;
    if (idv_count != 1 || idv_at != 6) begin
      failures++;
      $display("FAIL incr_data_valid: pulses=%0d at beat %0d, required 1 at beat 6", idv_count, idv_at);
    end
    checks++;
    if (ob_grant !== '0) begin
      failures++;
      $display("FAIL incr_release: grant=%b, required 0000", ob_grant);
    end
    do_reset();
  endtask

  task automatic test_wrap8_read();
    int n, pulses, ec;
    set_req(2, 3'd4, 32'h200, 1'b0, 1, 0);
    n = 0;
    do begin cycle(); n++; end while (!ob_hb && n < 10);
    checks++;
    if (!ob_hb || ob_hburst !== 3'd4 || ob_hw !== 1'b0) begin
      failures++;
      $display("FAIL wrap8_start: hb=%b HBUSER=%0d HWSUSER=%b, required 1 4 0", ob_hb, ob_hburst, ob_hw);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ob_ack[2]) expc_q.push_back(cyc + 2);
      if (ob_rdv !== '0) begin
        pulses++;
        checks++;
        if (ob_rdv !== 4'b0100 || ob_rdd !== hruser_drv) begin
          failures++;
          $display("FAIL wrap8_rd%0d: rd_valid=%b rd_data=%h, required 0100 %h", pulses, ob_rdv, ob_rdd, hruser_drv);
        end
        ec = (expc_q.size() > 0) ? expc_q.pop_front() : -1;
        checks++;
        if (cyc != ec) begin
          failures++;
          $display("FAIL wrap8_rd_time%0d: return at cycle %0d, required %0d", pulses, cyc, ec);
        end
      end
    end
    checks++;
    if (pulses != 8 || expc_q.size() != 0) begin
      failures++;
      $display("FAIL wrap8_count: %0d rd_valid pulses, %0d outstanding, required 8 and 0", pulses, expc_q.size());
    end
    expc_q.delete();
    do_reset();
  endtask

  task automatic test_starvation();
    int n, hbs, bad;
    int cnt [NREQ];
    int exp_cnt [NREQ];
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      set_req(i, 3'd0, 32'h1000 + 32'(i * 16), 1'b1, 1000, 0);
`ifdef AHB_ARB_FIXED_PRIO_EN
      exp_cnt[i] = (i == 0) ? 40 : 0;
`else
      exp_cnt[i] = 10;
`endif
    end
    hbs = 0; n = 0; bad = 0;
    while (hbs < 40 && n < 400) begin
      cycle(); n++;
      if (ob_hb) begin
        hbs++;
        if (!$onehot(ob_grant)) bad++;
        for (int i = 0; i < NREQ; i++) if (ob_grant[i]) cnt[i]++;
      end
    end
    checks++;
    if (hbs != 40 || bad != 0) begin
      failures++;
      $display("FAIL starve_total: %0d grants (%0d not one-hot), required 40 and 0", hbs, bad);
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (cnt[i] != exp_cnt[i]) begin
        failures++;
        $display("FAIL starve_req%0d: granted %0d times, required %0d", i, cnt[i], exp_cnt[i]);
      end
    end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    HRESETn = 1'b0; req_valid = '0; req_addr = '0; req_burst = '0; req_size = '0;
    req_write = '0; req_wdata = '0; req_last = '0; HREAdy = 1'b1; HRUSER = '0; read_valid = 1'b0;
    hruser_drv = '0;
    clear_model();
    test_reset();
    test_round_robin();
    test_incr4_write();
    test_incr_last();
    test_wrap8_read();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
